ntt_bf_sequencer: RTL

//  Upstream controller for ntt_arith_unit. Holds one N-point coefficient vector and walks all

---
 rtl/ntt_pkg.sv | 42 ++++
 rtl/ntt_addr_gen.sv | 78 +++++++
 rtl/ntt_arith_unit.sv | 70 +++++++
 rtl/ntt_bf_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared opcodes, sequencer states and twiddle table for the NTT datapath
//
// Purpose: constants shared by the butterfly sequencer, its address generator
//          and the arithmetic unit.
// Contents: OP_* arith opcodes, seq_state_e, NTT_N / NTT_LOG_N defaults,
//           tw_rom() twiddle table lookup (8 entries).
package ntt_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_BF   = 3'd3;
  localparam logic [2:0] OP_ROM  = 3'd4;

  localparam int NTT_N     = 8;
  localparam int NTT_LOG_N = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROM  = 3'd1,
    ST_BF   = 3'd2,
    ST_WB   = 3'd3,
    ST_FIN  = 3'd4
  } seq_state_e;

  // Twiddle table: successive powers of 3, returned unreduced.
  function automatic logic [63:0] tw_rom(input logic [2:0] idx);
    logic [63:0] val;
    case (idx)
      3'd0:    val = 64'd1;
      3'd1:    val = 64'd3;
      3'd2:    val = 64'd9;
      3'd3:    val = 64'd27;
      3'd4:    val = 64'd81;
      3'd5:    val = 64'd243;
      3'd6:    val = 64'd729;
      default: val = 64'd2187;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - stage/group/k counters and butterfly index generation
//
// Purpose: walks radix-2 DIT butterflies in stage, group, k order.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr_i         zero all counters
//   adv_i         step to the next butterfly
//   i_o, j_o      butterfly element indices (j = i + half)
//   tw_idx_o      twiddle ROM index k << (LOG_N-1-s)
//   last_o        current butterfly is the final one of the final stage
module ntt_addr_gen #(
  parameter int N     = 8,
  parameter int LOG_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [LOG_N-1:0] i_o,
  output logic [LOG_N-1:0] j_o,
  output logic [LOG_N-1:0] tw_idx_o,
  output logic             last_o
);

  logic [LOG_N-1:0] s_q, s_d, g_q, g_d, k_q, k_d;
  logic [LOG_N-1:0] half, k_max, g_max;
  logic             last_k, last_g, last_s;

  always_comb begin
    half   = LOG_N'(1) << s_q;
    k_max  = half - LOG_N'(1);
    g_max  = LOG_N'(((N / 2) >> s_q) - 1);
    last_k = (k_q == k_max);
    last_g = (g_q == g_max);
    last_s = (s_q == LOG_N'(LOG_N - 1));
    // k < half, so the group base and k occupy disjoint bits.
    i_o      = (g_q << (s_q + LOG_N'(1))) | k_q;
    j_o      = i_o | half;
    tw_idx_o = k_q << (LOG_N'(LOG_N - 1) - s_q);
    last_o   = last_k && last_g && last_s;
  end

  always_comb begin
    s_d = s_q;
    g_d = g_q;
    k_d = k_q;
    if (clr_i) begin
      s_d = '0;
      g_d = '0;
      k_d = '0;
    end else if (adv_i) begin
      if (!last_k) begin
        k_d = k_q + LOG_N'(1);
      end else begin
        k_d = '0;
        if (!last_g) begin
          g_d = g_q + LOG_N'(1);
        end else begin
          g_d = '0;
          s_d = last_s ? '0 : s_q + LOG_N'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      g_q <= '0;
      k_q <= '0;
    end else begin
      s_q <= s_d;
      g_q <= g_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/ntt_arith_unit.sv
// rtl/ntt_arith_unit.sv - registered modular ALU with butterfly and twiddle ROM ops
//
// Purpose: executes one opcode per cycle; results are registered and valid
//          the cycle after issue.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   opcode_i [2:0]    OP_ADD/OP_MULT/OP_SUB/OP_BF/OP_ROM
//   op_a_i/op_b_i     operands (assumed < q); op_a_i[2:0] is the ROM index
//   op_w_i            twiddle for OP_BF
//   op_q_i            modulus
//   res_out_1_o       sum / product / difference / BF upper / ROM value
//   res_out_2_o       BF lower output, 0 otherwise
module ntt_arith_unit
  import ntt_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   opcode_i,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  input  logic [W-1:0] op_w_i,
  input  logic [W-1:0] op_q_i,
  output logic [W-1:0] res_out_1_o,
  output logic [W-1:0] res_out_2_o
);

  logic [W-1:0]   res_1_q, res_1_d, res_2_q, res_2_d;
  logic [2*W-1:0] a2, b2, w2, qq, t2, r1, r2;

  always_comb begin
    a2 = {{W{1'b0}}, op_a_i};
    b2 = {{W{1'b0}}, op_b_i};
    w2 = {{W{1'b0}}, op_w_i};
    // A zero modulus (idle drive after reset) would divide by zero; mod 1 yields 0.
    qq = (op_q_i == '0) ? {{(2*W-1){1'b0}}, 1'b1} : {{W{1'b0}}, op_q_i};
    t2 = '0;
    r1 = '0;
    r2 = '0;
    case (opcode_i)
      OP_ADD:  r1 = (a2 + b2) % qq;
      OP_MULT: r1 = (a2 * b2) % qq;
      OP_SUB:  r1 = (a2 + qq - (b2 % qq)) % qq;
      OP_BF: begin
        t2 = (w2 * b2) % qq;
        r1 = (a2 + t2) % qq;
        r2 = (a2 + qq - t2) % qq;
      end
      OP_ROM:  r1 = {{W{1'b0}}, W'(tw_rom(op_a_i[2:0]))};
      default: r1 = '0;
    endcase
    res_1_d = r1[W-1:0];
    res_2_d = r2[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_1_q <= '0;
      res_2_q <= '0;
    end else begin
      res_1_q <= res_1_d;
      res_2_q <= res_2_d;
    end
  end

  assign res_out_1_o = res_1_q;
  assign res_out_2_o = res_2_q;

endmodule

// File: rtl/ntt_bf_sequencer.sv
// rtl/ntt_bf_sequencer.sv - in-place NTT butterfly sequencer driving ntt_arith_unit
//
// Purpose: holds an N-point vector (loaded bit-reversed) and runs every DIT
//          stage through the external arith unit: ROM fetch, BF, writeback.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_i, q_i             run request (IDLE only) and modulus latched on accept
//   ld_en_i/ld_addr_i/ld_data_i  host load port, ignored while busy
//   rd_addr_i, rd_data_o     combinational readout
//   busy_o, done_o           run in progress / one-cycle completion pulse
//   au_opcode_o, au_op_a_o, au_op_b_o, au_op_w_o, au_op_q_o  arith unit drive
//   au_res_1_i, au_res_2_i   registered arith results
module ntt_bf_sequencer
  import ntt_pkg::*;
#(
  parameter int N     = NTT_N,
  parameter int LOG_N = NTT_LOG_N,
  parameter int W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [W-1:0]     q_i,
  input  logic             ld_en_i,
  input  logic [LOG_N-1:0] ld_addr_i,
  input  logic [W-1:0]     ld_data_i,
  input  logic [LOG_N-1:0] rd_addr_i,
  output logic [W-1:0]     rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       au_opcode_o,
  output logic [W-1:0]     au_op_a_o,
  output logic [W-1:0]     au_op_b_o,
  output logic [W-1:0]     au_op_w_o,
  output logic [W-1:0]     au_op_q_o,
  input  logic [W-1:0]     au_res_1_i,
  input  logic [W-1:0]     au_res_2_i
);

  seq_state_e       state_q, state_d;
  logic [W-1:0]     modulus_q;
  logic [W-1:0]     mem_q [N];
  logic [LOG_N-1:0] idx_i, idx_j, tw_idx;
  logic             last_bf, accept, in_wb;

  assign accept = (state_q == ST_IDLE) && start_i;
  assign in_wb  = (state_q == ST_WB);

  ntt_addr_gen #(
    .N     (N),
    .LOG_N (LOG_N)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .adv_i    (in_wb),
    .i_o      (idx_i),
    .j_o      (idx_j),
    .tw_idx_o (tw_idx),
    .last_o   (last_bf)
  );

  always_comb begin
    state_d     = state_q;
    au_opcode_o = OP_ADD;
    au_op_a_o   = '0;
    au_op_b_o   = '0;
    au_op_w_o   = '0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_ROM;
      ST_ROM: begin
        au_opcode_o = OP_ROM;
        au_op_a_o   = W'(tw_idx);
        state_d     = ST_BF;
      end
      ST_BF: begin
        // au_res_1_i carries the twiddle fetched in ROM; it is registered in the arith unit.
        au_opcode_o = OP_BF;
        au_op_a_o   = mem_q[idx_i];
        au_op_b_o   = mem_q[idx_j];
        au_op_w_o   = au_res_1_i;
        state_d     = ST_WB;
      end
      ST_WB:   state_d = last_bf ? ST_FIN : ST_ROM;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      modulus_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) modulus_q <= q_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N; n++) mem_q[n] <= '0;
    end else if ((state_q == ST_IDLE) && ld_en_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end else if (in_wb) begin
      mem_q[idx_i] <= au_res_1_i;
      mem_q[idx_j] <= au_res_2_i;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_FIN);
  assign au_op_q_o = modulus_q;
  assign rd_data_o = mem_q[rd_addr_i];

endmodule
